// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state type, S-box and round-constant helpers.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic {IDLE, RUN} state_t;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [0:AES_WORD_W-1] sub_word(input logic [0:AES_WORD_W-1] w);
    return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_round_step.sv
// Combinational AES-128 key-schedule step: first-word generator plus w0..w3 XOR cascade.
import aes_pkg::*;

module key_round_step #(
  parameter int ROUND_W = 4
) (
  input  logic [0:AES_KEY_W-1] i_key,
  input  logic [0:ROUND_W-1]   i_round,
  output logic [0:AES_KEY_W-1] o_key
);

  logic [0:AES_WORD_W-1] w_rot;
  logic [0:AES_WORD_W-1] w_t;
  logic [0:AES_WORD_W-1] w_w0;
  logic [0:AES_WORD_W-1] w_w1;
  logic [0:AES_WORD_W-1] w_w2;
  logic [0:AES_WORD_W-1] w_w3;

  assign w_rot = {i_key[104:127], i_key[96:103]};
  assign w_t   = sub_word(w_rot) ^ {rcon(4'(i_round)), 24'h000000};

  assign w_w0  = i_key[0:31]   ^ w_t;
  assign w_w1  = i_key[32:63]  ^ w_w0;
  assign w_w2  = i_key[64:95]  ^ w_w1;
  assign w_w3  = i_key[96:127] ^ w_w2;

  assign o_key = {w_w0, w_w1, w_w2, w_w3};

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key scheduler: one round key per clock, rounds 0..NUM_ROUNDS.
// Optional KEY_STORE_EN macro adds an 11-entry round-key store with combinational read.
import aes_pkg::*;

module key_expansion_seq #(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int ROUND_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [0:AES_KEY_W-1] key_in,
  output logic [0:AES_KEY_W-1] round_key,
  output logic [0:ROUND_W-1]   round_num,
  output logic                 key_valid,
  output logic                 busy,
`ifdef KEY_STORE_EN
  input  logic [0:ROUND_W-1]   rd_addr,
  output logic [0:AES_KEY_W-1] rd_key,
`endif
  output logic                 done
);

  localparam logic [0:ROUND_W-1] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [0:AES_KEY_W-1] r_round_key;
  logic [0:ROUND_W-1]   r_round_num;
  logic                 r_key_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_last;
  logic [0:ROUND_W-1]   w_next_round;
  logic [0:AES_KEY_W-1] w_step_key;

  assign w_next_round = r_round_num + ROUND_W'(1);

  key_round_step #(.ROUND_W(ROUND_W)) u_step (
    .i_key   (r_round_key),
    .i_round (w_next_round),
    .o_key   (w_step_key)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = RUN;
        w_accept    = 1'b1;
      end
      RUN: if (r_round_num == LAST_ROUND) begin
        w_state_nxt = IDLE;
        w_last      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_round_key <= '0;
      r_round_num <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_round_key <= key_in;
        r_round_num <= '0;
        r_key_valid <= 1'b1;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
      end else if (w_last) begin
        // round_key/round_num deliberately hold the final round for downstream use
        r_key_valid <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
      end else if (r_state == RUN) begin
        r_round_num <= w_next_round;
        r_round_key <= w_step_key;
        r_done      <= (w_next_round == LAST_ROUND);
      end
    end
  end

`ifdef KEY_STORE_EN
  logic [0:AES_KEY_W-1] r_store [0:NUM_ROUNDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) r_store[i] <= '0;
    end else if (r_key_valid) begin
      r_store[r_round_num] <= r_round_key;
    end
  end

  assign rd_key = (rd_addr <= LAST_ROUND) ? r_store[rd_addr] : '0;
`endif

  assign round_key = r_round_key;
  assign round_num = r_round_num;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Self-checking bench for key_expansion_seq: FIPS-197 vectors plus random keys
// against a word-level key-schedule model with an S-box derived from GF(2^8).
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;
`ifdef KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] cap_r1;
  logic [127:0] cap_r10;
  logic         cap_done10;

  key_expansion_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .busy      (busy),
`ifdef KEY_STORE_EN
    .rd_addr   (rd_addr),
    .rd_key    (rd_key),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-by-word expansion into 44 words, regrouped into 11 round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the DUT idle. poke_round re-pulses start with another key,
  // abort_round asserts rst, hold leaves start high for a back-to-back restart.
  task automatic run_seq(input logic [127:0] key, input int poke_round,
                         input int abort_round, input bit hold);
    expand(key);
    start  = 1'b1;
    key_in = key;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("valid_r%0d", r), 128'(key_valid), 128'(1));
      chk($sformatf("busy_r%0d", r),  128'(busy),      128'(1));
      chk($sformatf("num_r%0d", r),   128'(round_num), 128'(r));
      chk($sformatf("key_r%0d", r),   round_key,       exp_rk[r]);
      chk($sformatf("done_r%0d", r),  128'(done),      128'(r == 10));
      if (r == 1)  cap_r1 = round_key;
      if (r == 10) begin cap_r10 = round_key; cap_done10 = done; end
      if (r == abort_round) begin
        rst = 1'b1;
        #1;
        chk("abort_key",   round_key,       128'(0));
        chk("abort_num",   128'(round_num), 128'(0));
        chk("abort_valid", 128'(key_valid), 128'(0));
        chk("abort_busy",  128'(busy),      128'(0));
        chk("abort_done",  128'(done),      128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_valid", 128'(key_valid), 128'(0));
        chk("post_abort_done",  128'(done),      128'(0));
        return;
      end
      if (r == poke_round) begin
        start  = 1'b1;
        key_in = ~key;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("end_valid", 128'(key_valid), 128'(0));
    chk("end_busy",  128'(busy),      128'(0));
    chk("end_done",  128'(done),      128'(0));
    chk("end_num",   128'(round_num), 128'(10));
    chk("end_key",   round_key,       exp_rk[10]);
  endtask

  initial begin
    logic [127:0] rkey;
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
`ifdef KEY_STORE_EN
    rd_addr = 4'd0;
`endif
    build_sbox();
    @(negedge clk);
    @(negedge clk);
    chk("rst_key",   round_key,       128'(0));
    chk("rst_num",   128'(round_num), 128'(0));
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_busy",  128'(busy),      128'(0));
    chk("rst_done",  128'(done),      128'(0));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 appendix A.1 key
    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, -1, 1'b0);
    chk("fips_r1",    cap_r1,  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10",   cap_r10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_done",  128'(cap_done10), 128'(1));
`ifdef KEY_STORE_EN
    rd_addr = 4'd10; #1;
    chk("store_10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_addr = 4'd0;  #1;
    chk("store_0",  rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_addr = 4'd5;  #1;
    chk("store_5",  rd_key, exp_rk[5]);
    rd_addr = 4'd12; #1;
    chk("store_12", rd_key, 128'(0));
    @(negedge clk);
`endif

    // all-zero key
    run_seq(128'h0, -1, -1, 1'b0);
    chk("zero_r1",  cap_r1,  128'h62636363626363636263636362636363);
    chk("zero_r10", cap_r10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start re-pulsed mid-run with a different key
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, 4, -1, 1'b0);

    // reset at round 6, then a fresh full sequence
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, -1, 6, 1'b0);
    run_seq(rkey, -1, -1, 1'b0);

    // start held high: one idle cycle, then second run loads the new key
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, -1, -1, 1'b1);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, -1, -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_seq(rkey, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
